// File: rtl/vga_rd_arbiter.sv
// Two-master AXI4 read arbiter: CPU on port 0, VGA on port 1.
// Whole bursts are granted round-robin; beat count is checked against arlen.
module vga_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s0_arvalid,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [ID_W-1:0]   s0_arid,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  output logic              s0_arready,
  output logic              s0_rvalid,
  output logic [1:0]        s0_rresp,
  output logic [DATA_W-1:0] s0_rdata,
  output logic              s0_rlast,
  output logic [ID_W-1:0]   s0_rid,
  input  logic              s0_rready,
  input  logic              s1_arvalid,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [ID_W-1:0]   s1_arid,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  output logic              s1_arready,
  output logic              s1_rvalid,
  output logic [1:0]        s1_rresp,
  output logic [DATA_W-1:0] s1_rdata,
  output logic              s1_rlast,
  output logic [ID_W-1:0]   s1_rid,
  input  logic              s1_rready,
  output logic              m_arvalid,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [ID_W-1:0]   m_arid,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  input  logic              m_arready,
  input  logic              m_rvalid,
  input  logic [1:0]        m_rresp,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_rlast,
  input  logic [ID_W-1:0]   m_rid,
  output logic              m_rready,
  output logic              grant,
  output logic              busy,
  output logic              len_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_AR,
    S_R
  } state_t;

  state_t     r_state;
  state_t     w_state_nx;
  logic       r_grant;
  logic       w_grant_nx;
  logic       r_last_grant;
  logic [8:0] r_beat_cnt;
  logic [7:0] r_len_q;
  logic       r_len_err;

  logic       w_sel_arvalid;
  logic [7:0] w_sel_arlen;
  logic       w_sel_rready;
  logic       w_in_ar;
  logic       w_in_r;
  logic       w_ar_hs;
  logic       w_r_hs;
  logic       w_len_bad;

  assign w_sel_arvalid = r_grant ? s1_arvalid : s0_arvalid;
  assign w_sel_arlen   = r_grant ? s1_arlen   : s0_arlen;
  assign w_sel_rready  = r_grant ? s1_rready  : s0_rready;

  assign w_in_ar = (r_state == S_AR);
  assign w_in_r  = (r_state == S_R);
  assign w_ar_hs = w_in_ar & w_sel_arvalid & m_arready;
  assign w_r_hs  = w_in_r & m_rvalid & w_sel_rready;

  // early rlast, or a non-last beat where the final one was due
  assign w_len_bad = m_rlast ? (r_beat_cnt != {1'b0, r_len_q})
                             : (r_beat_cnt == {1'b0, r_len_q});

  assign grant   = r_grant;
  assign busy    = (r_state != S_IDLE);
  assign len_err = r_len_err;

  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    unique case (r_state)
      S_IDLE: begin
        if (s0_arvalid | s1_arvalid) begin
          w_state_nx = S_AR;
          if (s0_arvalid & s1_arvalid) begin
            w_grant_nx = ~r_last_grant;
          end else begin
            w_grant_nx = s1_arvalid;
          end
        end
      end
      S_AR: begin
        if (w_ar_hs) w_state_nx = S_R;
      end
      S_R: begin
        if (w_r_hs & m_rlast) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    m_arvalid  = 1'b0;
    m_araddr   = '0;
    m_arid     = '0;
    m_arlen    = '0;
    m_arsize   = '0;
    m_arburst  = '0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    m_rready   = 1'b0;
    s0_rvalid  = 1'b0;
    s0_rresp   = '0;
    s0_rdata   = '0;
    s0_rlast   = 1'b0;
    s0_rid     = '0;
    s1_rvalid  = 1'b0;
    s1_rresp   = '0;
    s1_rdata   = '0;
    s1_rlast   = 1'b0;
    s1_rid     = '0;
    if (w_in_ar) begin
      m_arvalid = w_sel_arvalid;
      m_araddr  = r_grant ? s1_araddr  : s0_araddr;
      m_arid    = r_grant ? s1_arid    : s0_arid;
      m_arlen   = w_sel_arlen;
      m_arsize  = r_grant ? s1_arsize  : s0_arsize;
      m_arburst = r_grant ? s1_arburst : s0_arburst;
      if (r_grant) s1_arready = m_arready;
      else         s0_arready = m_arready;
    end
    if (w_in_r) begin
      m_rready = w_sel_rready;
      if (r_grant) begin
        s1_rvalid = m_rvalid;
        s1_rresp  = m_rresp;
        s1_rdata  = m_rdata;
        s1_rlast  = m_rlast;
        s1_rid    = m_rid;
      end else begin
        s0_rvalid = m_rvalid;
        s0_rresp  = m_rresp;
        s0_rdata  = m_rdata;
        s0_rlast  = m_rlast;
        s0_rid    = m_rid;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b0;
      r_beat_cnt   <= '0;
      r_len_q      <= '0;
      r_len_err    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      if (w_ar_hs) begin
        r_len_q    <= w_sel_arlen;
        r_beat_cnt <= '0;
      end
      if (w_r_hs) begin
        if (r_beat_cnt != 9'h1ff) r_beat_cnt <= r_beat_cnt + 9'd1;
        if (m_rlast)              r_last_grant <= r_grant;
        if (w_len_bad)            r_len_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_rd_arbiter.sv
// Bench for vga_rd_arbiter: transaction-level owner model, memory slave
// model, and directed bursts with hand-computed expectations.
module tb_vga_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          s0_arvalid = 1'b0;
  logic [AW-1:0] s0_araddr = '0;
  logic [IW-1:0] s0_arid = '0;
  logic [7:0]    s0_arlen = '0;
  logic [2:0]    s0_arsize = '0;
  logic [1:0]    s0_arburst = '0;
  logic          s0_arready;
  logic          s0_rvalid;
  logic [1:0]    s0_rresp;
  logic [DW-1:0] s0_rdata;
  logic          s0_rlast;
  logic [IW-1:0] s0_rid;
  logic          s0_rready = 1'b1;
  logic          s1_arvalid = 1'b0;
  logic [AW-1:0] s1_araddr = '0;
  logic [IW-1:0] s1_arid = '0;
  logic [7:0]    s1_arlen = '0;
  logic [2:0]    s1_arsize = '0;
  logic [1:0]    s1_arburst = '0;
  logic          s1_arready;
  logic          s1_rvalid;
  logic [1:0]    s1_rresp;
  logic [DW-1:0] s1_rdata;
  logic          s1_rlast;
  logic [IW-1:0] s1_rid;
  logic          s1_rready = 1'b1;
  logic          m_arvalid;
  logic [AW-1:0] m_araddr;
  logic [IW-1:0] m_arid;
  logic [7:0]    m_arlen;
  logic [2:0]    m_arsize;
  logic [1:0]    m_arburst;
  logic          m_arready = 1'b1;
  logic          m_rvalid = 1'b0;
  logic [1:0]    m_rresp = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_rlast = 1'b0;
  logic [IW-1:0] m_rid = '0;
  logic          m_rready;
  logic          grant;
  logic          busy;
  logic          len_err;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cyc = 0;
  int fall_gap = 0;
  int gap1 = 0;
  int beats0 = 0;
  int beats1 = 0;
  int short_at = -1;
  logic bp = 1'b0;
  bit glog[$];

  vga_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset),
    .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arid(s0_arid),
    .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_arready(s0_arready), .s0_rvalid(s0_rvalid), .s0_rresp(s0_rresp),
    .s0_rdata(s0_rdata), .s0_rlast(s0_rlast), .s0_rid(s0_rid),
    .s0_rready(s0_rready),
    .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arid(s1_arid),
    .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_arready(s1_arready), .s1_rvalid(s1_rvalid), .s1_rresp(s1_rresp),
    .s1_rdata(s1_rdata), .s1_rlast(s1_rlast), .s1_rid(s1_rid),
    .s1_rready(s1_rready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rresp(m_rresp),
    .m_rdata(m_rdata), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_rready(m_rready),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  // memory slave: handshakes sampled mid-cycle, applied after the edge
  logic       ar_hs_q = 1'b0;
  logic       r_hs_q = 1'b0;
  logic       rl_q = 1'b0;
  logic [7:0] ar_len_q = '0;
  logic [AW-1:0] ar_base_q = '0;
  logic [IW-1:0] ar_id_q = '0;

  initial forever begin
    @(negedge clock);
    ar_hs_q   = m_arvalid & m_arready;
    r_hs_q    = m_rvalid & m_rready;
    rl_q      = m_rlast;
    ar_len_q  = m_arlen;
    ar_base_q = m_araddr;
    ar_id_q   = m_arid;
  end

  initial begin : slave
    bit s_act;
    int s_idx;
    int s_len;
    logic [AW-1:0] s_base;
    logic [IW-1:0] s_id;
    s_act = 0; s_idx = 0; s_len = 0; s_base = '0; s_id = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        s_act = 0;
      end else begin
        if (r_hs_q) begin
          if (rl_q) s_act = 0;
          else      s_idx++;
        end
        if (ar_hs_q) begin
          s_act  = 1;
          s_idx  = 0;
          s_len  = int'(ar_len_q);
          s_base = ar_base_q;
          s_id   = ar_id_q;
        end
      end
      m_rvalid = s_act;
      m_rdata  = s_act ? {s_base, 32'(s_idx)} : '0;
      m_rresp  = s_act ? 2'(s_idx) : 2'd0;
      m_rid    = s_act ? s_id : '0;
      m_rlast  = s_act && (s_idx == s_len || s_idx == short_at);
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    s1_rready = bp ? ~s1_rready : 1'b1;
  end

  // owner model: who holds the memory port and in which phase
  int md_own = -1;
  bit md_addr = 0;
  bit md_grant = 0;
  int md_lastg = 0;
  bit md_err = 0;
  int md_cnt = 0;
  int md_len = 0;

  initial forever begin : model
    logic [51:0] e_ar;
    logic [71:0] e_r0, e_r1, mr;
    logic e_mrr;
    bit own_ar, own_r;
    @(negedge clock);
    own_ar = md_own >= 0 && md_addr;
    own_r  = md_own >= 0 && !md_addr;
    mr = {m_rvalid, m_rresp, m_rlast, m_rid, m_rdata};
    e_ar = '0;
    if (own_ar && md_own == 0)
      e_ar = {s0_arvalid, s0_araddr, s0_arid, s0_arlen, s0_arsize,
              s0_arburst, m_arready, 1'b0};
    if (own_ar && md_own == 1)
      e_ar = {s1_arvalid, s1_araddr, s1_arid, s1_arlen, s1_arsize,
              s1_arburst, 1'b0, m_arready};
    e_r0 = (own_r && md_own == 0) ? mr : '0;
    e_r1 = (own_r && md_own == 1) ? mr : '0;
    e_mrr = own_r && (md_own == 1 ? s1_rready : s0_rready);
    chk("ar", 128'({m_arvalid, m_araddr, m_arid, m_arlen, m_arsize,
                    m_arburst, s0_arready, s1_arready}), 128'(e_ar));
    chk("r0", 128'({s0_rvalid, s0_rresp, s0_rlast, s0_rid, s0_rdata}),
        128'(e_r0));
    chk("r1", 128'({s1_rvalid, s1_rresp, s1_rlast, s1_rid, s1_rdata}),
        128'(e_r1));
    chk("mrready", 128'(m_rready), 128'(e_mrr));
    chk("status", 128'({busy, busy ? grant : 1'b0, len_err}),
        128'({md_own >= 0, md_own >= 0 ? md_grant : 1'b0, md_err}));
    if (reset) begin
      md_own = -1; md_addr = 0; md_grant = 0; md_lastg = 0;
      md_err = 0; md_cnt = 0; md_len = 0;
    end else if (md_own < 0) begin
      if (s0_arvalid || s1_arvalid) begin
        if (s0_arvalid && s1_arvalid) md_own = 1 - md_lastg;
        else md_own = s1_arvalid ? 1 : 0;
        md_grant = (md_own == 1);
        md_addr = 1;
      end
    end else if (md_addr) begin
      if (e_ar[51] && m_arready) begin
        md_addr = 0;
        md_cnt = 0;
        md_len = md_own == 1 ? int'(s1_arlen) : int'(s0_arlen);
      end
    end else if (m_rvalid && e_mrr) begin
      if (m_rlast) begin
        if (md_cnt != md_len) md_err = 1;
        md_lastg = md_own;
        md_own = -1;
      end else if (md_cnt == md_len) begin
        md_err = 1;
      end
      if (md_cnt < 511) md_cnt++;
    end
  end

  // per-port beat scoreboard: data must be {base, beat index}
  initial forever begin : mon
    logic [AW-1:0] base0, base1;
    int idx0, idx1;
    bit busy_q;
    @(negedge clock);
    if (s0_arvalid && s0_arready) begin base0 = s0_araddr; idx0 = 0; end
    if (s1_arvalid && s1_arready) begin base1 = s1_araddr; idx1 = 0; end
    if (s0_rvalid && s0_rready) begin
      chk("data0", 128'(s0_rdata), 128'({base0, 32'(idx0)}));
      idx0++;
      beats0++;
    end
    if (s1_rvalid && s1_rready) begin
      chk("data1", 128'(s1_rdata), 128'({base1, 32'(idx1)}));
      idx1++;
      beats1++;
    end
    if (m_rvalid && m_rready && m_rlast) last_cyc = cyc;
    if (busy && !busy_q) glog.push_back(grant);
    if (!busy && busy_q) fall_gap = cyc - last_cyc;
    busy_q = busy;
  end

  task automatic req(input int p, input logic [31:0] a,
                     input logic [7:0] l, input logic [3:0] id,
                     output int wt);
    if (p == 0) begin
      s0_araddr = a; s0_arlen = l; s0_arid = id;
      s0_arsize = 3'd3; s0_arburst = 2'd1; s0_arvalid = 1'b1;
    end else begin
      s1_araddr = a; s1_arlen = l; s1_arid = id;
      s1_arsize = 3'd3; s1_arburst = 2'd1; s1_arvalid = 1'b1;
    end
    wt = -1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clock);
      if (p == 0 ? s0_arready : s1_arready) begin
        wt = k;
        chk("ar_addr", 128'(m_araddr), 128'(a));
        if (p == 1) gap1 = cyc - last_cyc;
        break;
      end
    end
    chk("ar_timeout", 128'(wt < 0), 128'(0));
    @(posedge clock);
    #1;
    if (p == 0) s0_arvalid = 1'b0;
    else        s1_arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (busy && k < 3000);
    chk("idle_timeout", 128'(busy), 128'(0));
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin : stim
    int w0, w1, b0, b1, gsz;
    repeat (2) @(negedge clock);
    chk("rst_state", 128'({busy, grant, len_err, m_arvalid, m_rready,
                           s0_arready, s1_arready, s0_rvalid, s1_rvalid}),
        128'(0));
    chk("rst_addr", 128'({m_araddr, m_arlen, s1_rdata}), 128'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;

    // VGA only, 200 beats
    b0 = beats0; b1 = beats1;
    req(1, 32'h8000_0000, 8'd199, 4'd3, w1);
    chk("a_lat", 128'(w1), 128'(1));
    wait_idle();
    chk("a_beats1", 128'(beats1 - b1), 128'(200));
    chk("a_beats0", 128'(beats0 - b0), 128'(0));
    chk("a_lenerr", 128'(len_err), 128'(0));
    chk("a_busyfall", 128'(fall_gap), 128'(1));

    // simultaneous requests after reset: VGA first, then alternate
    do_reset();
    b0 = beats0; b1 = beats1; gsz = glog.size();
    fork
      req(0, 32'h0000_1000, 8'd0, 4'd2, w0);
      req(1, 32'h8000_0000, 8'd199, 4'd5, w1);
    join
    wait_idle();
    chk("b_beats0", 128'(beats0 - b0), 128'(1));
    chk("b_beats1", 128'(beats1 - b1), 128'(200));
    fork
      req(0, 32'h0000_2000, 8'd3, 4'd6, w0);
      req(1, 32'h8000_4000, 8'd3, 4'd7, w1);
    join
    wait_idle();
    chk("b_gcount", 128'(glog.size() - gsz), 128'(4));
    if (glog.size() >= gsz + 4) begin
      chk("b_g0", 128'(glog[gsz]), 128'(1));
      chk("b_g1", 128'(glog[gsz+1]), 128'(0));
      chk("b_g2", 128'(glog[gsz+2]), 128'(1));
      chk("b_g3", 128'(glog[gsz+3]), 128'(0));
    end

    // VGA waits behind a CPU burst already in the data phase
    b0 = beats0; b1 = beats1;
    fork
      req(0, 32'h0000_3000, 8'd15, 4'd1, w0);
      begin
        repeat (6) @(posedge clock);
        #1;
        req(1, 32'h8000_8000, 8'd7, 4'd9, w1);
      end
    join
    wait_idle();
    chk("c_gap", 128'(gap1), 128'(2));
    chk("c_beats0", 128'(beats0 - b0), 128'(16));
    chk("c_beats1", 128'(beats1 - b1), 128'(8));

    // VGA backpressure
    bp = 1'b1;
    b1 = beats1;
    req(1, 32'h8000_1000, 8'd199, 4'd4, w1);
    wait_idle();
    bp = 1'b0;
    chk("e_beats1", 128'(beats1 - b1), 128'(200));

    // early rlast on the 150th beat, then a good burst
    short_at = 149;
    b1 = beats1;
    req(1, 32'h8001_0000, 8'd199, 4'd8, w1);
    wait_idle();
    short_at = -1;
    chk("f_lenerr", 128'(len_err), 128'(1));
    chk("f_beats1", 128'(beats1 - b1), 128'(150));
    req(0, 32'h0000_4000, 8'd3, 4'd2, w0);
    wait_idle();
    chk("f_sticky", 128'(len_err), 128'(1));

    // reset on beat 50 of a VGA burst
    b1 = beats1;
    req(1, 32'h8002_0000, 8'd199, 4'd1, w1);
    for (int k = 0; k < 500 && beats1 - b1 < 50; k++) @(negedge clock);
    chk("g_beat50", 128'(beats1 - b1), 128'(50));
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("g_rst_out", 128'({busy, grant, len_err, m_arvalid, m_rready,
                           s0_arready, s1_arready, s0_rvalid, s1_rvalid}),
        128'(0));
    chk("g_rst_data", 128'({s1_rdata, m_araddr}), 128'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    b0 = beats0;
    req(0, 32'h0000_5000, 8'd0, 4'd3, w0);
    chk("g_lat", 128'(w0), 128'(1));
    wait_idle();
    chk("g_beats0", 128'(beats0 - b0), 128'(1));
    chk("g_grant", 128'(glog[glog.size()-1]), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
